lii_stream_gearbox_wrapper: RTL and testbench

Parametrised successor of the per-kernel LII stream wrappers. It sits between one LII physical input/output channel pair and an HLS kernel's AXI-Stream ports. It handles kernel widths wider than the packing width PW by gathering and serialising multi-beat words, and it filters inbound beats by destination ID. It also buffers kernel output in a small FIFO and drives the kernel clock enable from FIFO occupancy rather than from the output ready alone.

---
 rtl/lii_stream_gearbox_wrapper.sv | 187 ++++++++++++++++++
 tb/tb_lii_stream_gearbox_wrapper.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lii_stream_gearbox_wrapper.sv
// -----------------------------------------------------------------------------
// lii_stream_gearbox_wrapper
//
// Bridges one LII physical channel pair to an HLS kernel's AXI-Stream ports.
// Inbound beats addressed to SRC_ID are gathered into kernel words of KIW
// bits. Beats addressed elsewhere are consumed and counted. Kernel output
// words of KOW bits are buffered in a small FIFO and serialised as PW-bit
// beats. The kernel clock enable is derived from FIFO occupancy, so a word
// already in flight when ce falls still has a free slot to land in.
//
// Ports
//   aclk, arstn          clock, synchronous active-low reset
//   lii_in_p0_*          inbound LII beat stream (tdata/tvalid/tready/src/dst)
//   lii_out_p0_*         outbound LII beat stream (src/dst are constants)
//   in_stream_*          gathered kernel input word (AXI-Stream master)
//   out_stream_*         kernel output word (AXI-Stream slave)
//   ce                   kernel clock enable
//   drop_cnt             saturating count of beats dropped on ID mismatch
// -----------------------------------------------------------------------------
module lii_stream_gearbox_wrapper #(
   parameter int         PW          = 1024,
   parameter int         KIW         = 384,
   parameter int         KOW         = 1024,
   parameter int         OFIFO_DEPTH = 4,
   parameter logic [7:0] SRC_ID      = 8'd0,
   parameter logic [7:0] DST_ID      = 8'd1
) (
   input  logic           aclk,
   input  logic           arstn,
   input  logic [PW-1:0]  lii_in_p0_tdata,
   input  logic           lii_in_p0_tvalid,
   output logic           lii_in_p0_tready,
   input  logic [7:0]     lii_in_p0_src,
   input  logic [7:0]     lii_in_p0_dst,
   output logic [PW-1:0]  lii_out_p0_tdata,
   output logic           lii_out_p0_tvalid,
   input  logic           lii_out_p0_tready,
   output logic [7:0]     lii_out_p0_src,
   output logic [7:0]     lii_out_p0_dst,
   output logic [KIW-1:0] in_stream_tdata,
   output logic           in_stream_tvalid,
   input  logic           in_stream_tready,
   input  logic [KOW-1:0] out_stream_tdata,
   input  logic           out_stream_tvalid,
   output logic           out_stream_tready,
   output logic           ce,
   output logic [15:0]    drop_cnt
);

   localparam int IN_BEATS  = (KIW + PW - 1) / PW;
   localparam int OUT_BEATS = (KOW + PW - 1) / PW;
   // Counters keep at least one bit; with a single beat they simply stay 0.
   localparam int ICW = (IN_BEATS  > 1) ? $clog2(IN_BEATS)  : 1;
   localparam int OCW = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
   localparam int AW  = $clog2(OFIFO_DEPTH);
   localparam int CW  = AW + 1;

   localparam logic [ICW-1:0] IN_LAST  = ICW'(IN_BEATS - 1);
   localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_BEATS - 1);
   localparam logic [CW-1:0]  DEPTH_C  = CW'(OFIFO_DEPTH);
   localparam logic [CW-1:0]  CE_MAX   = CW'(OFIFO_DEPTH - 2);

   // ---------------------------------------------------------------- input gather
   logic [IN_BEATS*PW-1:0] acc_q, acc_d;
   logic [ICW-1:0]         in_cnt_q, in_cnt_d;
   logic                   acc_full_q, acc_full_d;
   logic [15:0]            drop_q, drop_d;
   logic                   in_take, in_hs, in_match;

   assign in_take          = acc_full_q & in_stream_tready;
   // Readies are forced low while reset is held so nothing is consumed.
   assign lii_in_p0_tready = arstn & (~acc_full_q | in_stream_tready);
   assign in_hs            = lii_in_p0_tvalid & lii_in_p0_tready;
   assign in_match         = (lii_in_p0_dst == SRC_ID);

   always_comb begin
      // NOTE: every next-state signal is given a default first; any path that
      // left one unassigned would infer a latch.
      acc_d      = acc_q;
      in_cnt_d   = in_cnt_q;
      acc_full_d = acc_full_q & ~in_take;
      drop_d     = drop_q;
      if (in_hs) begin
         if (in_match) begin
            acc_d[int'(in_cnt_q)*PW +: PW] = lii_in_p0_tdata;
            if (in_cnt_q == IN_LAST) begin
               // A final beat landing on a take cycle refills the word at once.
               in_cnt_d   = '0;
               acc_full_d = 1'b1;
            end else begin
               in_cnt_d = in_cnt_q + ICW'(1);
            end
         end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
         end
      end
   end

   always_ff @(posedge aclk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before the edge.
      if (!arstn) begin
         acc_full_q <= 1'b0;
         in_cnt_q   <= '0;
         drop_q     <= '0;
      end else begin
         acc_full_q <= acc_full_d;
         in_cnt_q   <= in_cnt_d;
         drop_q     <= drop_d;
      end
   end

   // NOTE: data-only storage (accumulator, FIFO words) is not reset; the valid
   // flags and occupancy qualify it, and skipping the reset keeps it plain RAM/flops.
   always_ff @(posedge aclk) begin
      acc_q <= acc_d;
   end

   assign in_stream_tvalid = acc_full_q;
   assign in_stream_tdata  = acc_q[KIW-1:0];
   assign drop_cnt         = drop_q;

   // ---------------------------------------------------------------- output FIFO
   logic [KOW-1:0]         mem_q [OFIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]          count_q;
   logic [OCW-1:0]         out_cnt_q;
   logic                   push, pop, out_hs;
   logic [OUT_BEATS*PW-1:0] head_ext;

   assign out_stream_tready = arstn & (count_q != DEPTH_C);
   assign push              = out_stream_tvalid & out_stream_tready;
   assign lii_out_p0_tvalid = (count_q != '0);
   assign out_hs            = lii_out_p0_tvalid & lii_out_p0_tready;
   assign pop               = out_hs & (out_cnt_q == OUT_LAST);

   always_ff @(posedge aclk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= out_stream_tdata;
      end
   end

   always_ff @(posedge aclk) begin
      if (!arstn) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         out_cnt_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (out_hs) out_cnt_q <= pop ? '0 : out_cnt_q + OCW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // ---------------------------------------------------------------- serialiser
   // Head word zero-extended to whole beats so the last beat pads with 0.
   always_comb begin
      head_ext           = '0;
      head_ext[KOW-1:0]  = mem_q[rd_ptr_q];
   end

   assign lii_out_p0_tdata = head_ext[int'(out_cnt_q)*PW +: PW];
   assign lii_out_p0_src   = SRC_ID;
   assign lii_out_p0_dst   = DST_ID;

   // ---------------------------------------------------------------- clock enable
   // arstn_q holds ce low for the first cycle after reset release.
   logic arstn_q;

   always_ff @(posedge aclk) begin
      if (!arstn) arstn_q <= 1'b0;
      else        arstn_q <= 1'b1;
   end

   assign ce = arstn_q & (count_q <= CE_MAX) & ~(acc_full_q & ~in_stream_tready);

   // Inbound source ID and accumulator padding bits are intentionally unused.
   logic unused_bits;
   assign unused_bits = ^{lii_in_p0_src, acc_q};

endmodule

// File: tb/tb_lii_stream_gearbox_wrapper.sv
module tb_lii_stream_gearbox_wrapper;

   localparam int         PW        = 16;
   localparam int         KIW       = 24;
   localparam int         KOW       = 40;
   localparam int         DEPTH     = 4;
   localparam logic [7:0] SRC       = 8'h3C;
   localparam logic [7:0] DSTI      = 8'hA1;
   localparam int         IN_BEATS  = 2;
   localparam int         OUT_BEATS = 3;

   logic           aclk = 1'b0;
   logic           arstn;
   logic [PW-1:0]  lii_in_p0_tdata;
   logic           lii_in_p0_tvalid;
   logic           lii_in_p0_tready;
   logic [7:0]     lii_in_p0_src;
   logic [7:0]     lii_in_p0_dst;
   logic [PW-1:0]  lii_out_p0_tdata;
   logic           lii_out_p0_tvalid;
   logic           lii_out_p0_tready;
   logic [7:0]     lii_out_p0_src;
   logic [7:0]     lii_out_p0_dst;
   logic [KIW-1:0] in_stream_tdata;
   logic           in_stream_tvalid;
   logic           in_stream_tready;
   logic [KOW-1:0] out_stream_tdata;
   logic           out_stream_tvalid;
   logic           out_stream_tready;
   logic           ce;
   logic [15:0]    drop_cnt;

   always #5 aclk = ~aclk;

   lii_stream_gearbox_wrapper #(
      .PW(PW), .KIW(KIW), .KOW(KOW), .OFIFO_DEPTH(DEPTH), .SRC_ID(SRC), .DST_ID(DSTI)
   ) dut (
      .aclk(aclk), .arstn(arstn),
      .lii_in_p0_tdata(lii_in_p0_tdata), .lii_in_p0_tvalid(lii_in_p0_tvalid),
      .lii_in_p0_tready(lii_in_p0_tready), .lii_in_p0_src(lii_in_p0_src),
      .lii_in_p0_dst(lii_in_p0_dst),
      .lii_out_p0_tdata(lii_out_p0_tdata), .lii_out_p0_tvalid(lii_out_p0_tvalid),
      .lii_out_p0_tready(lii_out_p0_tready), .lii_out_p0_src(lii_out_p0_src),
      .lii_out_p0_dst(lii_out_p0_dst),
      .in_stream_tdata(in_stream_tdata), .in_stream_tvalid(in_stream_tvalid),
      .in_stream_tready(in_stream_tready),
      .out_stream_tdata(out_stream_tdata), .out_stream_tvalid(out_stream_tvalid),
      .out_stream_tready(out_stream_tready),
      .ce(ce), .drop_cnt(drop_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ reference model
   // Words waiting for the kernel, words waiting in the output FIFO, and the
   // beat sequence those words must produce on the LII output.
   logic [KIW-1:0]          kq [$];
   logic [KOW-1:0]          oq [$];
   logic [PW-1:0]           bq [$];
   logic [KIW-1:0]          in_log [$];
   logic [PW-1:0]           out_log [$];
   logic [IN_BEATS*PW-1:0]  part_word;
   logic [OUT_BEATS*PW-1:0] ext;
   int  part_cnt, beats_done, drop_m;
   bit  arst_q_m, started;
   bit  in_fire, out_fire, k_fire;
   bit  in_rdy_m, out_rdy_m, take_m;

   always @(negedge aclk) begin
      if (started) begin
         check("in_tvalid", in_stream_tvalid, kq.size() != 0);
         if (kq.size() != 0) check("in_tdata", in_stream_tdata, kq[0]);
         check("in_tready", lii_in_p0_tready, arstn && (kq.size() == 0 || in_stream_tready));
         check("drop_cnt", drop_cnt, drop_m);
         check("out_tvalid", lii_out_p0_tvalid, oq.size() != 0);
         if (oq.size() != 0) check("out_tdata", lii_out_p0_tdata, bq[0]);
         check("k_tready", out_stream_tready, arstn && oq.size() != DEPTH);
         check("ce", ce, arst_q_m && oq.size() <= DEPTH - 2 &&
                         !(kq.size() != 0 && !in_stream_tready));
      end
      in_fire  = 1'b0;
      out_fire = 1'b0;
      k_fire   = 1'b0;
      if (!arstn) begin
         kq.delete(); oq.delete(); bq.delete();
         part_cnt = 0; part_word = '0; beats_done = 0; drop_m = 0;
         arst_q_m = 1'b0;
         started  = 1'b1;
      end else if (started) begin
         in_rdy_m  = (kq.size() == 0 || in_stream_tready);
         out_rdy_m = (oq.size() != DEPTH);
         take_m    = (kq.size() != 0 && in_stream_tready);
         in_fire   = lii_in_p0_tvalid && in_rdy_m;
         out_fire  = (oq.size() != 0) && lii_out_p0_tready;
         k_fire    = out_stream_tvalid && out_rdy_m;
         if (take_m) begin
            in_log.push_back(in_stream_tdata);
            void'(kq.pop_front());
         end
         if (in_fire) begin
            if (lii_in_p0_dst == SRC) begin
               if (part_cnt == 0) part_word = '0;
               part_word = part_word | ((IN_BEATS*PW)'(lii_in_p0_tdata) << (part_cnt*PW));
               part_cnt++;
               if (part_cnt == IN_BEATS) begin
                  kq.push_back(part_word[KIW-1:0]);
                  part_cnt = 0;
               end
            end else if (drop_m < 65535) begin
               drop_m++;
            end
         end
         if (out_fire) begin
            out_log.push_back(lii_out_p0_tdata);
            void'(bq.pop_front());
            beats_done++;
            if (beats_done == OUT_BEATS) begin
               void'(oq.pop_front());
               beats_done = 0;
            end
         end
         if (k_fire) begin
            oq.push_back(out_stream_tdata);
            ext = (OUT_BEATS*PW)'(out_stream_tdata);
            for (int b = 0; b < OUT_BEATS; b++) bq.push_back(PW'(ext >> (b*PW)));
         end
         arst_q_m = 1'b1;
      end
   end

   // ------------------------------------------------------------ stimulus helpers
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic send_beat(input logic [PW-1:0] d, input logic [7:0] dst);
      bit done = 1'b0;
      lii_in_p0_tdata  = d;
      lii_in_p0_dst    = dst;
      lii_in_p0_tvalid = 1'b1;
      for (int t = 0; t < 64 && !done; t++) begin
         tick();
         done = in_fire;
      end
      if (!done) check("send_timeout", 0, 1);
      lii_in_p0_tvalid = 1'b0;
   endtask

   task automatic push_word(input logic [KOW-1:0] w);
      bit done = 1'b0;
      out_stream_tdata  = w;
      out_stream_tvalid = 1'b1;
      for (int t = 0; t < 64 && !done; t++) begin
         tick();
         done = k_fire;
      end
      if (!done) check("push_timeout", 0, 1);
      out_stream_tvalid = 1'b0;
   endtask

   int base;
   logic [1:0] exp_ce, exp_rdy;

   initial begin
      arstn = 1'b0;
      lii_in_p0_tdata = '0; lii_in_p0_tvalid = 1'b0; lii_in_p0_src = 8'h00;
      lii_in_p0_dst = SRC; lii_out_p0_tready = 1'b0; in_stream_tready = 1'b0;
      out_stream_tdata = '0; out_stream_tvalid = 1'b0;
      repeat (3) tick();
      check("rst_in_tvalid", in_stream_tvalid, 0);
      check("rst_out_tvalid", lii_out_p0_tvalid, 0);
      check("rst_ce", ce, 0);
      check("rst_drop", drop_cnt, 0);
      check("out_src", lii_out_p0_src, 8'h3C);
      check("out_dst", lii_out_p0_dst, 8'hA1);
      arstn = 1'b1;
      tick();

      // Gather with an interleaved foreign beat.
      send_beat(16'h1111, SRC);
      check("mid_word_tvalid", in_stream_tvalid, 0);
      send_beat(16'h0BAD, 8'h05);
      send_beat(16'h2222, SRC);
      check("gather_latency", in_stream_tvalid, 1);
      check("gather_word", in_stream_tdata, 24'h221111);
      check("drop_one", drop_cnt, 1);
      tick();
      check("in_stall", lii_in_p0_tready, 0);
      lii_in_p0_tdata = 16'h3333; lii_in_p0_dst = SRC; lii_in_p0_tvalid = 1'b1;
      in_stream_tready = 1'b1;
      #1 check("beat_on_take", lii_in_p0_tready, 1);
      tick();
      lii_in_p0_tvalid = 1'b0;
      in_stream_tready = 1'b0;
      send_beat(16'h4444, SRC);
      check("second_word", in_stream_tdata, 24'h443333);
      in_stream_tready = 1'b1;
      tick();
      in_stream_tready = 1'b0;
      check("log_word0", in_log[0], 24'h221111);
      check("log_word1", in_log[1], 24'h443333);

      // Serialise one word with a partial last beat.
      lii_out_p0_tready = 1'b1;
      base = out_log.size();
      push_word(40'hAB_CDEF_0123);
      check("out_latency", lii_out_p0_tvalid, 1);
      check("out_first_beat", lii_out_p0_tdata, 16'h0123);
      repeat (6) tick();
      check("beat0", out_log[base], 16'h0123);
      check("beat1", out_log[base+1], 16'hCDEF);
      check("beat2_pad", out_log[base+2], 16'h00AB);

      // Fill the FIFO with the LII output stalled.
      in_stream_tready  = 1'b1;
      lii_out_p0_tready = 1'b0;
      base = out_log.size();
      out_stream_tdata  = 40'h10_0000_0000;
      out_stream_tvalid = 1'b1;
      exp_ce  = 2'b11;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("fill_ce", ce, (i < 2) ? 1 : 0);
         check("fill_kready", out_stream_tready, (i < 3) ? 1 : 0);
         if (k_fire) out_stream_tdata = out_stream_tdata + 40'd1;
      end
      repeat (3) tick();
      check("full_ce", ce, 0);
      check("full_kready", out_stream_tready, 0);
      check("full_out_tvalid", lii_out_p0_tvalid, 1);
      lii_out_p0_tready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (k_fire) out_stream_tvalid = 1'b0;
      end
      check("fill_no_loss", out_log.size() - base, 15);

      // Reset in the middle of a word with two words queued.
      lii_out_p0_tready = 1'b0;
      in_stream_tready  = 1'b0;
      push_word(40'h55_AAAA_5555);
      push_word(40'h66_BBBB_6666);
      send_beat(16'h7777, SRC);
      arstn = 1'b0;
      tick();
      check("mr_in_tvalid", in_stream_tvalid, 0);
      check("mr_out_tvalid", lii_out_p0_tvalid, 0);
      check("mr_drop", drop_cnt, 0);
      check("mr_ce", ce, 0);
      check("mr_in_tready", lii_in_p0_tready, 0);
      arstn = 1'b1;
      lii_out_p0_tready = 1'b1;
      send_beat(16'h5555, SRC);
      send_beat(16'h6666, SRC);
      check("post_reset_word", in_stream_tdata, 24'h665555);
      in_stream_tready = 1'b1;
      tick();

      // Randomised traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (!lii_in_p0_tvalid || in_fire) begin
            lii_in_p0_tvalid = ($urandom_range(0, 3) != 0);
            lii_in_p0_tdata  = PW'($urandom);
            lii_in_p0_src    = 8'($urandom);
            case ($urandom_range(0, 5))
               0:       lii_in_p0_dst = 8'h05;
               1:       lii_in_p0_dst = SRC ^ 8'h01;
               default: lii_in_p0_dst = SRC;
            endcase
         end
         if (!out_stream_tvalid || k_fire) begin
            out_stream_tvalid = ($urandom_range(0, 2) != 0);
            out_stream_tdata  = {8'($urandom), 32'($urandom)};
         end
         in_stream_tready  = ($urandom_range(0, 2) != 0);
         lii_out_p0_tready = ($urandom_range(0, 2) != 0);
         arstn = ($urandom_range(0, 799) != 0);
      end

      // Drain.
      arstn = 1'b1;
      lii_in_p0_tvalid = 1'b0;
      out_stream_tvalid = 1'b0;
      in_stream_tready = 1'b1;
      lii_out_p0_tready = 1'b1;
      repeat (30) tick();
      check("drained_out", lii_out_p0_tvalid, 0);
      check("drained_in", in_stream_tvalid, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
